// File: rtl/logic_unit_arbiter_if.sv
// Request/result bundle for the shared logic-unit arbiter.
// master: requesters + result consumer; slave: the arbiter.
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [7:0]         op;
    logic [4*WIDTH-1:0] a;
    logic [4*WIDTH-1:0] b;
    logic [3:0]         gnt;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic [1:0]         res_id;
    logic               busy;
    logic [15:0]        op_count;

    modport master (
        output req, op, a, b, res_ready,
        input  gnt, res_valid, res_data, res_id, busy, op_count
    );

    modport slave (
        input  req, op, a, b, res_ready,
        output gnt, res_valid, res_data, res_id, busy, op_count
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of one shared bitwise logic unit.
// Ports: clk, rst (sync, active-high), bus (slave side of the if).
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    logic_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win_q, win_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         gnt_q, gnt_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [1:0]         res_id_q, res_id_d;
    logic               busy_q, busy_d;
    logic [15:0]        op_count_q, op_count_d;

    logic [1:0]         pick;
    logic [1:0]         idx;
    logic               found;
    logic [WIDTH-1:0]   lu_res;

    // First requesting index at or after ptr, wrapping mod 4.
    always_comb begin
        pick  = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        lu_res = '0;
        unique case (op_q)
            2'b00: lu_res = ~a_q;
            2'b01: lu_res = a_q & b_q;
            2'b10: lu_res = a_q | b_q;
            2'b11: lu_res = a_q ^ b_q;
            default: lu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    op_d    = bus.op[{pick, 1'b0} +: 2];
                    a_d     = bus.a[pick*WIDTH +: WIDTH];
                    b_d     = bus.b[pick*WIDTH +: WIDTH];
                    // Registered, so the pulse lands in the EXEC cycle.
                    gnt_d   = 4'b0001 << pick;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = lu_res;
                res_id_d    = win_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    ptr_d       = win_q + 2'd1;
                    if (op_count_q != 16'hFFFF) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter (WIDTH=8).
// Vector table plus hand sequences for stall, reset and saturation.
module tb_logic_unit_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic_unit_arbiter_if #(.WIDTH(8)) bus();

    logic_unit_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic [7:0]  data;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge idle.
    task automatic run_txn(input logic [3:0] req, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] egnt, input logic [7:0] edata,
                           input logic [1:0] eid, input logic [15:0] ecnt,
                           input string nm);
        bus.req = req;
        bus.op  = op;
        bus.a   = a;
        bus.b   = b;
        tick();
        chk({nm, " gnt"}, 32'(bus.gnt), 32'(egnt));
        chk({nm, " busy/valid exec"}, {30'd0, bus.busy, bus.res_valid},
            32'b10);
        tick();
        chk({nm, " resp"},
            {17'd0, bus.res_valid, bus.gnt, bus.res_id, bus.res_data},
            {17'd0, 1'b1, 4'b0000, eid, edata});
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        bus.req = '0;
        chk({nm, " done valid/busy"}, {30'd0, bus.res_valid, bus.busy},
            32'd0);
        chk({nm, " op_count"}, 32'(bus.op_count), 32'(ecnt));
    endtask

    initial begin
        tbl[0] = '{4'hF, 8'h39, 32'h3C0FF0CC, 32'h00FF0FAA, 4'b0001, 8'h88, 2'd0};
        tbl[1] = '{4'hF, 8'h39, 32'h3C0FF0CC, 32'h00FF0FAA, 4'b0010, 8'hFF, 2'd1};
        tbl[2] = '{4'hF, 8'h39, 32'h3C0FF0CC, 32'h00FF0FAA, 4'b0100, 8'hF0, 2'd2};
        tbl[3] = '{4'hF, 8'h39, 32'h3C0FF0CC, 32'h00FF0FAA, 4'b1000, 8'hC3, 2'd3};
        tbl[4] = '{4'hF, 8'h39, 32'h3C0FF0CC, 32'h00FF0FAA, 4'b0001, 8'h88, 2'd0};
        tbl[5] = '{4'h1, 8'h00, 32'h000000A5, 32'h00000000, 4'b0001, 8'h5A, 2'd0};
        tbl[6] = '{4'h4, 8'h20, 32'h00550000, 32'h00AA0000, 4'b0100, 8'hFF, 2'd2};
        tbl[7] = '{4'h5, 8'h03, 32'h001200FF, 32'h0000000F, 4'b0001, 8'hF0, 2'd0};
        tbl[8] = '{4'hA, 8'h84, 32'h0000F300, 32'h00003F00, 4'b0010, 8'h33, 2'd1};

        bus.req       = '0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.res_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outs",
            {8'd0, bus.gnt, bus.res_valid, bus.busy, bus.res_id, bus.res_data},
            32'd0);
        chk("reset op_count", 32'(bus.op_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle no req", {30'd0, bus.busy, bus.res_valid}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].req, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].gnt,
                    tbl[i].data, tbl[i].id, 16'(i + 1),
                    $sformatf("vec%0d", i));
        end

        // Stall with backpressure; operands/req change after grant;
        // res_ready high in IDLE and EXEC is ignored.
        bus.req = 4'h8;
        bus.op  = 8'hC0;
        bus.a   = 32'hA5000000;
        bus.b   = 32'h0F000000;
        bus.res_ready = 1'b1;
        tick();
        chk("stall gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        bus.op  = '0;
        bus.a   = '0;
        bus.b   = '0;
        tick();
        bus.res_ready = 1'b0;
        chk("stall first resp",
            {16'd0, bus.res_valid, bus.busy, bus.gnt, bus.res_id, bus.res_data},
            {16'd0, 1'b1, 1'b1, 4'd0, 2'd3, 8'hAA});
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("stall hold %0d", c),
                {16'd0, bus.res_valid, bus.busy, bus.gnt, bus.res_id,
                 bus.res_data},
                {16'd0, 1'b1, 1'b1, 4'd0, 2'd3, 8'hAA});
        end
        chk("stall op_count", 32'(bus.op_count), 32'd9);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("stall done", {15'd0, bus.res_valid, bus.op_count},
            {15'd0, 1'b0, 16'd10});

        run_txn(4'h1, 8'h00, 32'h0000000F, 32'h0, 4'b0001, 8'hF0, 2'd0,
                16'd11, "pre exec rst");

        // Reset while in EXEC.
        bus.req = 4'h4;
        tick();
        chk("exec rst gnt", 32'(bus.gnt), 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = '0;
        chk("exec rst outs",
            {13'd0, bus.gnt, bus.busy, bus.res_valid, bus.op_count},
            32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("exec rst quiet %0d", c),
                {26'd0, bus.gnt, bus.res_valid, bus.busy}, 32'd0);
        end

        run_txn(4'h2, 8'h08, 32'h00001100, 32'h00002200, 4'b0010, 8'h33,
                2'd1, 16'd1, "pre resp rst");

        // Reset while in RESP; pointer must restart at 0.
        bus.req = 4'h1;
        bus.op  = 8'h00;
        bus.a   = 32'h0;
        tick();
        chk("resp rst gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("resp rst valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = '0;
        chk("resp rst outs",
            {13'd0, bus.gnt, bus.busy, bus.res_valid, bus.op_count},
            32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("resp rst quiet %0d", c),
                {26'd0, bus.gnt, bus.res_valid, bus.busy}, 32'd0);
        end
        run_txn(4'h9, 8'hC1, 32'h000000F0, 32'h000000FF, 4'b0001, 8'hF0,
                2'd0, 16'd1, "post rst ptr0");

        // Saturation: preload the counter just below its ceiling.
        force dut.op_count_q = 16'hFFFE;
        tick();
        release dut.op_count_q;
        tick();
        chk("preset op_count", 32'(bus.op_count), 32'h0000FFFE);
        run_txn(4'h2, 8'h0C, 32'h0000FF00, 32'h00000F00, 4'b0010, 8'hF0,
                2'd1, 16'hFFFF, "sat reach");
        run_txn(4'h4, 8'h00, 32'h00330000, 32'h0, 4'b0100, 8'hCC,
                2'd2, 16'hFFFF, "sat hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
